// File: rtl/io_bus_bridge_multi.sv
// Avalon-MM slave bridge that splits 32-bit word accesses into byte transfers on one of
// g_ports 8-bit I/O buses, with per-byte ack timeout and synchronised IRQ aggregation.
module io_bus_bridge_multi #(
  parameter int g_ports      = 2,
  parameter int g_addr_width = 20,
  parameter int g_timeout    = 255,
  localparam int C_SEL = (g_ports > 1) ? $clog2(g_ports) : 1
) (
  input  logic                              sys_clock_clk,
  input  logic                              sys_reset_reset_n,
  input  logic [C_SEL+g_addr_width-3:0]     avs_address,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [3:0]                        avs_byteenable,
  input  logic [31:0]                       avs_writedata,
  output logic [31:0]                       avs_readdata,
  output logic                              avs_waitrequest,
  output logic [g_ports*g_addr_width-1:0]   io_address,
  output logic [g_ports-1:0]                io_read,
  output logic [g_ports-1:0]                io_write,
  output logic [g_ports*8-1:0]              io_wdata,
  input  logic [g_ports*8-1:0]              io_rdata,
  input  logic [g_ports-1:0]                io_ack,
  input  logic [g_ports-1:0]                io_irq,
  output logic                              irq,
  output logic [g_ports-1:0]                irq_status,
  output logic                              timeout_flag,
  input  logic                              timeout_clr
);
  localparam int WW = g_addr_width - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [C_SEL-1:0]   sel_reg, sel_next, req_sel;
  logic [WW-1:0]      word_reg, word_next, req_word;
  logic [3:0]         pend_reg, pend_next, rem;
  logic [1:0]         lane_reg, lane_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic               wr_reg;
  logic [15:0]        cnt_reg;
  logic [31:0]        rdata_reg;
  logic               flag_reg;
  logic [g_ports-1:0] sync1_reg, sync2_reg;
  logic               irq_reg;
  logic               req, req_ok, ack_sel, timed_out, lane_finish;
  logic [7:0]         rdata_sel;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  assign req_sel  = avs_address[C_SEL+WW-1 -: C_SEL];
  assign req_word = avs_address[WW-1:0];
  assign req      = avs_read | avs_write;
  assign req_ok   = int'(req_sel) < g_ports;

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = 8'h00;
    for (int p = 0; p < g_ports; p++) begin
      if (int'(sel_reg) == p) begin
        ack_sel   = io_ack[p];
        rdata_sel = io_rdata[p*8 +: 8];
      end
    end
  end

  // An ack arriving on the last allowed wait cycle still wins over the timeout.
  assign timed_out   = (state_reg == WAIT) && !ack_sel && (cnt_reg == 16'(g_timeout - 1));
  assign lane_finish = (state_reg == WAIT) && (ack_sel || timed_out);
  assign rem         = pend_reg & ~(4'b0001 << lane_reg);

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    lane_next  = lane_reg;
    sel_next   = sel_reg;
    word_next  = word_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          sel_next   = req_sel;
          word_next  = req_word;
          wdata_next = avs_writedata;
          pend_next  = avs_byteenable;
          lane_next  = lowest(avs_byteenable);
          state_next = (avs_byteenable != 4'h0 && req_ok) ? ISSUE : DONE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (lane_finish) begin
          pend_next  = rem;
          lane_next  = lowest(rem);
          state_next = (rem != 4'h0) ? ISSUE : DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      word_reg  <= '0;
      pend_reg  <= '0;
      lane_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      word_reg  <= word_next;
      pend_reg  <= pend_next;
      lane_reg  <= lane_next;
      wdata_reg <= wdata_next;
      if (state_reg == IDLE && req) begin
        wr_reg <= avs_write;
        // Reads to a non-existent port complete at once with 0xFF on enabled lanes.
        for (int i = 0; i < 4; i++)
          rdata_reg[i*8 +: 8] <= (!avs_write && !req_ok && avs_byteenable[i]) ? 8'hFF : 8'h00;
      end
      if (state_reg == ISSUE)
        cnt_reg <= '0;
      else if (state_reg == WAIT)
        cnt_reg <= cnt_reg + 16'd1;
      if (lane_finish && !wr_reg)
        rdata_reg[{lane_reg, 3'b000} +: 8] <= timed_out ? 8'hFF : rdata_sel;
      if (timed_out)
        flag_reg <= 1'b1;
      else if (timeout_clr)
        flag_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < g_ports; gi++) begin : g_port
    logic [g_addr_width-1:0] addr_hold;
    logic [7:0]              wdata_hold;

    always_ff @(posedge sys_clock_clk or negedge sys_reset_reset_n) begin
      if (!sys_reset_reset_n) begin
        addr_hold  <= '0;
        wdata_hold <= '0;
      end else if (state_next == ISSUE && int'(sel_next) == gi) begin
        addr_hold  <= {word_next, lane_next};
        wdata_hold <= wdata_next[{lane_next, 3'b000} +: 8];
      end
    end

    assign io_address[gi*g_addr_width +: g_addr_width] = addr_hold;
    assign io_wdata[gi*8 +: 8] = wdata_hold;
    assign io_read[gi]  = (state_reg == ISSUE) && !wr_reg && (int'(sel_reg) == gi);
    assign io_write[gi] = (state_reg == ISSUE) &&  wr_reg && (int'(sel_reg) == gi);
  end

  always_ff @(posedge sys_clock_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      sync1_reg <= io_irq;
      sync2_reg <= sync1_reg;
      irq_reg   <= |sync2_reg;
    end
  end

  assign avs_waitrequest = (state_reg != DONE);
  assign avs_readdata    = rdata_reg;
  assign timeout_flag    = flag_reg;
  assign irq_status      = sync2_reg;
  assign irq             = irq_reg;
endmodule
